// File: rtl/demux_pkg.sv
// Shared defaults, select encodings and buffer occupancy states for the
// 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/demux_1x2_if.sv
// Stream bundle for demux_1x2: one valid/ready input carrying a select bit,
// and two valid/ready outputs.
interface demux_1x2_if import demux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  // Source and sinks sit on the master side; the demux is the slave.
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry FIFO used as the per-output buffer of demux_1x2. The head entry
// is a register that drives the output data directly.
module demux_fifo2 import demux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full
);

  occ_t             occ_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;

  // Occupancy state machine and entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_r  <= OCC_EMPTY;
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (push) begin
            head_r <= push_data;
            occ_r  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Push with pop replaces the outgoing head in place.
          if (push && pop) begin
            head_r <= push_data;
          end else if (push) begin
            tail_r <= push_data;
            occ_r  <= OCC_FULL;
          end else if (pop) begin
            occ_r  <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_r <= tail_r;
            occ_r  <= OCC_ONE;
          end
        end
        default: begin
          occ_r <= OCC_EMPTY;
        end
      endcase
    end
  end

  assign head_data = head_r;
  assign valid     = (occ_r != OCC_EMPTY);
  assign full      = (occ_r == OCC_FULL);

endmodule

// File: rtl/demux_1x2.sv
// Registered 1-to-2 stream demultiplexer: routes each input beat to one of
// two independently buffered outputs and counts the beats sent to each.
module demux_1x2 import demux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1x2_if.slave       bus,
  output logic [CNT_W-1:0] out0_beats,
  output logic [CNT_W-1:0] out1_beats
);

  logic             full0_s;
  logic             full1_s;
  logic             in_ready_s;
  logic             push0_s;
  logic             push1_s;
  logic             pop0_s;
  logic             pop1_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Ready depends only on the selected buffer's registered occupancy.
  always_comb begin
    in_ready_s = 1'b0;
    if (bus.in_sel == SEL_OUT1) begin
      in_ready_s = !full1_s;
    end else begin
      in_ready_s = !full0_s;
    end
  end

  // Route an accepted beat to the selected buffer.
  always_comb begin
    push0_s = 1'b0;
    push1_s = 1'b0;
    if (bus.in_valid && in_ready_s) begin
      push0_s = (bus.in_sel == SEL_OUT0);
      push1_s = (bus.in_sel == SEL_OUT1);
    end else begin
      push0_s = 1'b0;
      push1_s = 1'b0;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign pop0_s       = bus.out0_valid && bus.out0_ready;
  assign pop1_s       = bus.out1_valid && bus.out1_ready;

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0_s),
    .push_data (bus.in_data),
    .pop       (pop0_s),
    .head_data (bus.out0_data),
    .valid     (bus.out0_valid),
    .full      (full0_s)
  );

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1_s),
    .push_data (bus.in_data),
    .pop       (pop1_s),
    .head_data (bus.out1_data),
    .valid     (bus.out1_valid),
    .full      (full1_s)
  );

  // Per-output accepted-beat counters, wrapping silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else begin
      if (push0_s) begin
        cnt0_r <= cnt0_r + CNT_W'(1);
      end
      if (push1_s) begin
        cnt1_r <= cnt1_r + CNT_W'(1);
      end
    end
  end

  assign out0_beats = cnt0_r;
  assign out1_beats = cnt1_r;

endmodule
